spi_burst_ctrl: RTL and testbench
=================================

Name: spi_burst_ctrl

Overview:
- Transaction sequencer directly upstream of the SPI master in the SPI controller datapath.
- Host pushes up to 32 TX words, then issues start. The block launches one multi-word SPI burst and feeds each TX word onto the master's parallel input at the right time.
- Each received word from the master is captured into an RX buffer; the host drains it afterwards.
- The block only issues commands to the master; it never drives SCK, SS or MOSI.

Parameters:
- DATA_BITS, 8, SPI word width; must equal the master's DATA_BITS.
- CPOL, 0, idle SCK level; must equal the master's CPOL.
- MAX_WORDS, 32, TX/RX buffer depth; fixed by the master's 5-bit word counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. The master's n_rst is driven from ~rst at top level.
- tx_wr_en  in  1  push tx_wr_data into the TX buffer; ignored when full or busy.
- tx_wr_data  in  DATA_BITS  TX word.
- tx_level  out  6  TX words held, 0..32.
- start  in  1  one-cycle request to run a burst.
- num_words  in  6  burst length, sampled with start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the last RX word has been stored.
- err  out  1  one-cycle pulse when start is rejected.
- rx_rd_en  in  1  pop the RX buffer head; ignored when empty.
- rx_rd_data  out  DATA_BITS  RX buffer head (show-ahead).
- rx_level  out  6  RX words held.
- spi_en  out  1  to master spi_en.
- data_in  out  DATA_BITS  to master data_in.
- data_words  out  6  to master data_words.
- m_ready  in  1  master ready_out.
- m_valid  in  1  master valid_out, one-cycle pulse per completed word.
- m_data  in  DATA_BITS  master data_out.
- m_sck  in  1  master SCK, used only for word-start detection.

Behaviour:
- Reset values: busy=0, done=0, err=0, spi_en=0, data_words=0, data_in=0. tx_level=rx_level=0; both buffer pointers cleared.
- Reset mid-burst: aborts immediately, buffers emptied, spi_en low the next cycle.
- FSM states: IDLE, LAUNCH, RUN, FINISH.
- IDLE: start is accepted only when all of the following hold; otherwise err pulses for 1 cycle and the state is unchanged:
  - m_ready=1
  - 1 <= num_words <= tx_level
  - rx_level==0
- On accept: latch num_words into data_words (held until next accept), clear tx_ptr, word_started=0, go to LAUNCH.
- LAUNCH (1 cycle): spi_en=1, data_in=tx_buf[0], then go to RUN. spi_en is high in no other cycle.
- RUN, TX side:
  - data_in = tx_buf[tx_ptr] continuously.
  - A leading edge is a cycle where m_sck differs from its value registered one cycle earlier and the previous value equals CPOL.
  - On a leading edge while word_started=0: tx_ptr += 1 and set word_started.
  - m_valid clears word_started.
  - Result: word k+1 is stable on data_in from the first SCK edge of word k until that word is loaded, for any BRDV.
  - data_in is don't-care once tx_ptr == data_words.
- RUN, RX side:
  - On m_valid, write m_data to rx_buf[rx_wr_ptr] and increment rx_level.
  - Count stored words; when the count reaches data_words, go to FINISH.
- FINISH (1 cycle): done=1, tx_level and tx pointers cleared (TX contents consumed), go to IDLE.
- busy=1 in LAUNCH, RUN and FINISH.
- tx_wr_en while busy or tx_level==32: dropped, no error.
- rx_rd_en with rx_level==0: no effect.
- rx_rd_en while busy: allowed. A same-cycle rx pop and m_valid write leaves rx_level unchanged.
- start while busy: err pulse, burst unaffected.
- m_valid in IDLE: ignored.
- Pointer widths: 5 bits, wrapping at 32. Levels are 6 bits and saturate logically at 32 by the full checks above.

Decomposition:
- Package spi_ctrl_pkg: state enum (IDLE, LAUNCH, RUN, FINISH), MAX_WORDS=32, level/pointer width localparams.
- Sub-module spi_word_buf: sync-write, async-read, DATA_BITS x MAX_WORDS register array with independent wr/rd ports. Instantiated twice, for TX and RX.

Test Plan:
- Master with BRDV=2, CPHA=1, slave loops MOSI to MISO. Push 0xA5, 0x3C, 0xF0, start num_words=3 -> spi_en pulses once, data_words=3. rx_buf reads 0xA5, 0x3C, 0xF0, done pulses once, tx_level=0.
- Same traffic with master BRDV=8 -> identical RX data. Proves the word-start pointer advance is independent of BRDV.
- tx_level=2, start num_words=3 -> err pulse, busy stays 0. start num_words=0 -> err pulse.
- Push 32 words, start num_words=32 -> 32 m_valid pulses, rx_level=32, done. A 33rd push before start is dropped, tx_level stays 32.
- rst asserted in RUN after the 2nd m_valid -> next cycle busy=0, rx_level=0, tx_level=0, spi_en=0. A fresh 1-word burst then completes correctly.
- Pop RX during a burst so a pop coincides with m_valid -> rx_level unchanged that cycle, word order preserved.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// SPI burst controller shared definitions.
// Sequencer states and buffer geometry.
package spi_ctrl_pkg;

  localparam int MAX_WORDS = 32;
  localparam int PTR_W     = 5;
  localparam int LVL_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    FINISH
  } state_t;

endpackage

// File: rtl/spi_word_buf.sv
// Word buffer for the SPI burst controller.
// Sync write, async read, independent ports.
module spi_word_buf
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR_W-1:0]     wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [PTR_W-1:0]     rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [MAX_WORDS];

  // Store one word per enabled cycle
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI burst sequencer feeding the SPI master.
// Buffers TX/RX words around one multi-word burst.
module spi_burst_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int   DATA_BITS = 8,
  parameter logic CPOL      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_wr_en,
  input  logic [DATA_BITS-1:0] tx_wr_data,
  output logic [LVL_W-1:0]     tx_level,
  input  logic                 start,
  input  logic [LVL_W-1:0]     num_words,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 rx_rd_en,
  output logic [DATA_BITS-1:0] rx_rd_data,
  output logic [LVL_W-1:0]     rx_level,
  output logic                 spi_en,
  output logic [DATA_BITS-1:0] data_in,
  output logic [LVL_W-1:0]     data_words,
  input  logic                 m_ready,
  input  logic                 m_valid,
  input  logic [DATA_BITS-1:0] m_data,
  input  logic                 m_sck
);

  state_t state, state_nxt;

  logic [PTR_W-1:0]     tx_wr_ptr;
  logic [PTR_W-1:0]     tx_ptr;
  logic [PTR_W-1:0]     rx_wr_ptr;
  logic [PTR_W-1:0]     rx_rd_ptr;
  logic [LVL_W-1:0]     rx_cnt;
  logic [DATA_BITS-1:0] tx_rd_data;
  logic                 sck_q;
  logic                 word_started;

  logic tx_push;
  logic rx_push;
  logic rx_pop;
  logic start_ok;
  logic accept;
  logic lead_edge;
  logic last_word;

  assign busy = (state != IDLE);

  assign tx_push = tx_wr_en && !busy &&
                   (tx_level != LVL_W'(MAX_WORDS));

  assign start_ok = m_ready &&
                    (num_words != '0) &&
                    (num_words <= tx_level) &&
                    (rx_level == '0);

  assign accept = (state == IDLE) && start && start_ok;

  assign rx_push = (state == RUN) && m_valid;
  assign rx_pop  = rx_rd_en && (rx_level != '0);

  assign lead_edge = (m_sck != sck_q) && (sck_q == CPOL);

  assign last_word = rx_push &&
                     ((rx_cnt + LVL_W'(1)) == data_words);

  spi_word_buf #(
    .DATA_BITS(DATA_BITS)
  ) u_tx_buf (
    .clk    (clk),
    .wr_en  (tx_push),
    .wr_addr(tx_wr_ptr),
    .wr_data(tx_wr_data),
    .rd_addr(tx_ptr),
    .rd_data(tx_rd_data)
  );

  spi_word_buf #(
    .DATA_BITS(DATA_BITS)
  ) u_rx_buf (
    .clk    (clk),
    .wr_en  (rx_push),
    .wr_addr(rx_wr_ptr),
    .wr_data(m_data),
    .rd_addr(rx_rd_ptr),
    .rd_data(rx_rd_data)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and master-facing command outputs
  always_comb begin
    state_nxt = state;
    spi_en    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    data_in   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (start_ok) state_nxt = LAUNCH;
          else          err       = !rst;
        end
      end
      LAUNCH: begin
        spi_en    = 1'b1;
        data_in   = tx_rd_data;
        err       = start && !rst;
        state_nxt = RUN;
      end
      RUN: begin
        data_in = tx_rd_data;
        err     = start && !rst;
        if (last_word) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        err       = start && !rst;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst length latch and word-start TX pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      data_words   <= '0;
      tx_ptr       <= '0;
      word_started <= 1'b0;
      sck_q        <= CPOL;
    end else begin
      sck_q <= m_sck;
      if (accept) begin
        data_words   <= num_words;
        tx_ptr       <= '0;
        word_started <= 1'b0;
      end else if (state == RUN) begin
        if (lead_edge && !word_started) begin
          tx_ptr       <= tx_ptr + PTR_W'(1);
          word_started <= 1'b1;
        end else if (m_valid) begin
          word_started <= 1'b0;
        end
      end else if (state == FINISH) begin
        tx_ptr <= '0;
      end
    end
  end

  // TX fill pointer and level, consumed at burst end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_level  <= '0;
    end else if (state == FINISH) begin
      tx_wr_ptr <= '0;
      tx_level  <= '0;
    end else if (tx_push) begin
      tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      tx_level  <= tx_level + LVL_W'(1);
    end
  end

  // RX pointers, level and per-burst store count
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + LVL_W'(1);
        2'b01:   rx_level <= rx_level - LVL_W'(1);
        default: rx_level <= rx_level;
      endcase
      if (accept)       rx_cnt <= '0;
      else if (rx_push) rx_cnt <= rx_cnt + LVL_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Testbench for spi_burst_ctrl.
// Behavioural SPI master with MOSI looped to MISO.
module tb_spi_burst_ctrl;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_wr_en = 1'b0;
  logic [DB-1:0] tx_wr_data = '0;
  logic [5:0]    tx_level;
  logic          start = 1'b0;
  logic [5:0]    num_words = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic          rx_rd_en;
  logic [DB-1:0] rx_rd_data;
  logic [5:0]    rx_level;
  logic          spi_en;
  logic [DB-1:0] data_in;
  logic [5:0]    data_words;
  logic          m_ready;
  logic          m_valid;
  logic [DB-1:0] m_data;
  logic          m_sck;

  logic rd_man = 1'b0;
  logic follow = 1'b0;

  assign rx_rd_en = follow ? m_valid : rd_man;

  spi_burst_ctrl #(
    .DATA_BITS(DB),
    .CPOL     (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_wr_en  (tx_wr_en),
    .tx_wr_data(tx_wr_data),
    .tx_level  (tx_level),
    .start     (start),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rx_rd_en  (rx_rd_en),
    .rx_rd_data(rx_rd_data),
    .rx_level  (rx_level),
    .spi_en    (spi_en),
    .data_in   (data_in),
    .data_words(data_words),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_sck     (m_sck)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int exp_lvl = 0;
  bit bsy_m = 1'b0;
  int spi_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int spi0 = 0;
  int done0 = 0;
  int brdv = 2;

  bit          mbusy = 1'b0;
  int          mdiv, me, mw, mnw;
  logic [DB-1:0] mcur;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  // SPI master: CPHA=1, CPOL=0, BRDV clocks per half period
  task automatic master_step();
    if (rst) begin
      mbusy   = 1'b0;
      m_sck   = 1'b0;
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_data  = '0;
      mdiv    = 0;
    end else begin
      m_valid = 1'b0;
      if (!mbusy) begin
        if (spi_en) begin
          mbusy   = 1'b1;
          m_ready = 1'b0;
          mnw     = int'(data_words);
          mcur    = data_in;
          mw      = 0;
          me      = 0;
          mdiv    = 0;
        end
      end else begin
        mdiv++;
        if (mdiv >= brdv) begin
          mdiv = 0;
          if (me < 2 * DB) begin
            m_sck = ~m_sck;
            me++;
          end else begin
            m_valid = 1'b1;
            m_data  = mcur;
            mw++;
            me = 0;
            if (mw >= mnw) begin
              mbusy   = 1'b0;
              m_ready = 1'b1;
            end else begin
              mcur = data_in;
            end
          end
        end
      end
    end
  endtask

  initial begin
    m_sck   = 1'b0;
    m_ready = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      master_step();
    end
  end

  // Monitor: RX level model and in-order RX data scoreboard
  always @(negedge clk) begin
    if (spi_en) spi_cnt++;
    if (done) done_cnt++;
    if (m_valid && !rst) valid_cnt++;
    chk("rx_level", 32'(rx_level), 32'(exp_lvl));
    if (!rst && rx_rd_en && exp_lvl > 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_pop actual=%0h required=none",
                 rx_rd_data);
      end else if (rx_rd_data !== exp_q[0]) begin
        errors++;
        $display("FAIL rx_data actual=%0h required=%0h",
                 rx_rd_data, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
    if (rst) exp_lvl = 0;
    else exp_lvl = exp_lvl + (m_valid ? 1 : 0)
                 - ((rx_rd_en && exp_lvl > 0) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    tx_wr_en   = 1'b1;
    tx_wr_data = d;
    if (!bsy_m && tx_q.size() < 32) tx_q.push_back(d);
    tick();
    tx_wr_en = 1'b0;
  endtask

  task automatic try_start(input int n, output bit ok);
    ok = !bsy_m && n >= 1 && n <= tx_q.size()
         && exp_lvl == 0 && m_ready;
    start     = 1'b1;
    num_words = 6'(n);
    @(negedge clk);
    chk("err", 32'(err), 32'(!ok));
    tick();
    start = 1'b0;
    if (ok) begin
      for (int i = 0; i < n; i++) exp_q.push_back(tx_q[i]);
      bsy_m = 1'b1;
      spi0  = spi_cnt;
      done0 = done_cnt;
    end
  endtask

  task automatic finish_burst(input int n);
    int k;
    k = 0;
    while (done_cnt == done0 && k < 20000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_pulses", 32'(done_cnt - done0), 32'd1);
    chk("spi_en_pulses", 32'(spi_cnt - spi0), 32'd1);
    chk("data_words", 32'(data_words), 32'(n));
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("tx_level_after", 32'(tx_level), 32'd0);
    tx_q.delete();
    bsy_m = 1'b0;
    tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    rd_man = 1'b1;
    while (exp_lvl > 0 && k < 200) begin
      tick();
      k++;
    end
    rd_man = 1'b0;
  endtask

  task automatic run_fixed(input int br);
    bit ok;
    brdv = br;
    push(8'hA5);
    push(8'h3C);
    push(8'hF0);
    try_start(3, ok);
    if (ok) finish_burst(3);
    drain();
  endtask

  initial begin
    bit ok;
    int k, v0, n, extra;
    logic [7:0] d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_spi_en", 32'(spi_en), 32'd0);
    chk("rst_data_words", 32'(data_words), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_tx_level", 32'(tx_level), 32'd0);
    chk("rst_rx_level", 32'(rx_level), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_fixed(2);
    run_fixed(8);

    brdv = 2;
    push(8'h11);
    push(8'h22);
    try_start(3, ok);
    @(negedge clk);
    chk("busy_rej_len", 32'(busy), 32'd0);
    tick();
    try_start(0, ok);
    @(negedge clk);
    chk("busy_rej_zero", 32'(busy), 32'd0);
    tick();
    try_start(2, ok);
    if (ok) finish_burst(2);
    drain();

    for (int i = 0; i < 33; i++) push(8'($urandom));
    @(negedge clk);
    chk("tx_full", 32'(tx_level), 32'd32);
    tick();
    try_start(32, ok);
    if (ok) finish_burst(32);
    @(negedge clk);
    chk("rx_full", 32'(rx_level), 32'd32);
    tick();
    drain();

    brdv = 2;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    try_start(4, ok);
    v0 = valid_cnt;
    k = 0;
    while (valid_cnt < v0 + 2 && k < 5000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("two_valids", 32'(valid_cnt - v0), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tx_q.delete();
    exp_q.delete();
    bsy_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rx_level", 32'(rx_level), 32'd0);
    chk("abort_tx_level", 32'(tx_level), 32'd0);
    chk("abort_spi_en", 32'(spi_en), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(8'h5A);
    try_start(1, ok);
    if (ok) finish_burst(1);
    drain();

    brdv = 3;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    follow = 1'b1;
    try_start(5, ok);
    if (ok) finish_burst(5);
    follow = 1'b0;
    @(negedge clk);
    chk("follow_rx_level", 32'(rx_level), 32'd1);
    tick();
    drain();

    for (int it = 0; it < 8; it++) begin
      n     = int'($urandom_range(1, 10));
      extra = int'($urandom_range(0, 2));
      brdv  = int'($urandom_range(1, 6));
      for (int i = 0; i < n + extra; i++) push(8'($urandom));
      follow = 1'($urandom_range(0, 1));
      try_start(n, ok);
      if (ok) begin
        repeat (3) tick();
        try_start(1, ok);
        d = 8'($urandom);
        push(d);
        @(negedge clk);
        chk("tx_level_busy", 32'(tx_level),
            32'(tx_q.size()));
        tick();
        finish_burst(n);
      end
      follow = 1'b0;
      tick();
      drain();
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
